step_ramp_generator: RTL and testbench

//  Trapezoidal step-rate generator feeding the motor phase state machine.

---
 rtl/step_ramp_generator_pkg.sv | 19 +
 rtl/step_ramp_generator_timer.sv | 28 ++
 rtl/step_ramp_generator.sv | 159 +++++++++++++++
 tb/tb_step_ramp_generator.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/step_ramp_generator_pkg.sv
// Shared definitions for the trapezoidal step-rate generator.
package step_ramp_generator_pkg;

    localparam int CNT_W_DEF = 16;
    localparam int PER_W_DEF = 24;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCEL  = 2'd1;
    localparam logic [1:0] ST_CRUISE = 2'd2;
    localparam logic [1:0] ST_DECEL  = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = ST_IDLE,
        ACCEL  = ST_ACCEL,
        CRUISE = ST_CRUISE,
        DECEL  = ST_DECEL
    } state_t;

endpackage

// File: rtl/step_ramp_generator_timer.sv
// Loadable down-counter; expire is high in the cycle the count sits at 1,
// so a value of P loaded at one edge yields an expiry edge P cycles later.
module step_interval_timer #(
    parameter int PER_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [PER_W-1:0] load_val,
    input  logic             run,
    output logic             expire
);

    logic [PER_W-1:0] cnt;

    assign expire = run && (cnt == PER_W'(1));

    // Load wins over counting; the count parks at zero once it runs out.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (run && (cnt != '0))
            cnt <= cnt - PER_W'(1);
    end

endmodule

// File: rtl/step_ramp_generator.sv
// Trapezoidal step-rate generator: accelerate, cruise, decelerate.
//
//  state  | meaning
//  IDLE   | waiting for start; done pulse and zero-count moves finish here
//  ACCEL  | shortening the interval by ramp_delta each step
//  CRUISE | interval held at min_period
//  DECEL  | lengthening the interval back towards start_period
module step_ramp_generator
    import step_ramp_generator_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int PER_W = PER_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic [CNT_W-1:0] step_count,
    input  logic [PER_W-1:0] start_period,
    input  logic [PER_W-1:0] min_period,
    input  logic [PER_W-1:0] ramp_delta,
    output logic             make_step,
    output logic             busy,
    output logic             done,
    output logic [PER_W-1:0] cur_period
);

    state_t           state, state_n;
    logic [CNT_W-1:0] rem, rem_n, acc, acc_n;
    logic [PER_W-1:0] per, per_n, sp_q, sp_n, mp_q, mp_n, dl_q, dl_n;
    logic             busy_q, busy_n, last_q, last_n, done_q, done_n, step_q, step_n;
    logic             tmr_load, tmr_exp;

    logic [PER_W-1:0] sp_in, mp_in, mp_clamp, per_up, per_dn;
    logic [CNT_W-1:0] rem_dec, rem_strobe, rem_clip, acc_up, acc_dn;

    // Input sanitising: zero periods act as 1, cruise never slower than start.
    assign sp_in    = (start_period == '0) ? PER_W'(1) : start_period;
    assign mp_in    = (min_period == '0) ? PER_W'(1) : min_period;
    assign mp_clamp = (mp_in > sp_in) ? sp_in : mp_in;

    // Saturating ramp arithmetic; per always lies within [mp_q, sp_q].
    assign per_up = ((sp_q - per) > dl_q) ? per + dl_q : sp_q;
    assign per_dn = ((per > mp_q) && ((per - mp_q) > dl_q)) ? per - dl_q : mp_q;

    // rem may already be 0 when a stop truncated the move during the first
    // interval; that strobe is then the final one.
    assign rem_dec    = (rem == '0) ? '0 : rem - CNT_W'(1);
    assign rem_strobe = (stop && (acc < rem_dec)) ? acc : rem_dec;
    assign rem_clip   = (acc < rem) ? acc : rem;
    assign acc_up     = (acc == '1) ? acc : acc + CNT_W'(1);
    assign acc_dn     = (acc == '0) ? acc : acc - CNT_W'(1);

    step_interval_timer #(.PER_W(PER_W)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (per_n),
        .run      (busy_q && !last_q),
        .expire   (tmr_exp)
    );

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            rem    <= '0;
            acc    <= '0;
            per    <= '0;
            sp_q   <= '0;
            mp_q   <= '0;
            dl_q   <= '0;
            busy_q <= 1'b0;
            last_q <= 1'b0;
            done_q <= 1'b0;
            step_q <= 1'b0;
        end else begin
            state  <= state_n;
            rem    <= rem_n;
            acc    <= acc_n;
            per    <= per_n;
            sp_q   <= sp_n;
            mp_q   <= mp_n;
            dl_q   <= dl_n;
            busy_q <= busy_n;
            last_q <= last_n;
            done_q <= done_n;
            step_q <= step_n;
        end
    end

    // Next-state, step bookkeeping and ramp decisions.
    always_comb begin
        state_n  = state;
        rem_n    = rem;
        acc_n    = acc;
        per_n    = per;
        sp_n     = sp_q;
        mp_n     = mp_q;
        dl_n     = dl_q;
        busy_n   = busy_q;
        last_n   = last_q;
        done_n   = 1'b0;
        step_n   = 1'b0;
        tmr_load = 1'b0;

        if (last_q) begin
            // last_q marks the cycle between the final strobe (or a
            // zero-count start) and the done pulse.
            done_n  = 1'b1;
            busy_n  = 1'b0;
            last_n  = 1'b0;
            state_n = IDLE;
        end else if (state == IDLE) begin
            if (start) begin
                sp_n  = sp_in;
                mp_n  = mp_clamp;
                dl_n  = ramp_delta;
                rem_n = step_count;
                acc_n = '0;
                per_n = sp_in;
                if (step_count == '0) begin
                    last_n = 1'b1;
                end else begin
                    busy_n   = 1'b1;
                    state_n  = ACCEL;
                    tmr_load = 1'b1;
                end
            end
        end else if (tmr_exp) begin
            step_n = 1'b1;
            rem_n  = rem_strobe;
            if (rem_strobe == '0) begin
                last_n = 1'b1;
            end else if (rem_strobe <= acc) begin
                state_n  = DECEL;
                per_n    = per_up;
                acc_n    = acc_dn;
                tmr_load = 1'b1;
            end else if (state == ACCEL) begin
                per_n    = per_dn;
                acc_n    = acc_up;
                tmr_load = 1'b1;
                if (per_dn == mp_q)
                    state_n = CRUISE;
            end else begin
                tmr_load = 1'b1;
            end
        end else if (stop) begin
            rem_n = rem_clip;
        end
    end

    assign make_step  = step_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign cur_period = per;

endmodule

// File: tb/tb_step_ramp_generator.sv
// Directed bench for step_ramp_generator: strobe timing relative to the start edge.
module tb_step_ramp_generator;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [15:0] step_count = '0;
    logic [23:0] start_period = '0;
    logic [23:0] min_period = '0;
    logic [23:0] ramp_delta = '0;
    logic        make_step, busy, done;
    logic [23:0] cur_period;

    int n_chk  = 0;
    int n_pass = 0;
    int st_q[$];
    int done_t;
    logic busy_seen;
    int ev;

    int e_ramp[$]  = '{10, 18, 24, 28, 34, 42};
    int e_short[$] = '{10, 18, 24, 32, 42};
    int e_stop[$]  = '{10, 18, 24, 28, 32, 38, 46, 56};
    int e_clamp[$] = '{10, 20, 30};
    int e_fast[$]  = '{1, 2, 3, 4};
    int e_none[$];

    step_ramp_generator #(.CNT_W(16), .PER_W(24)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .stop         (stop),
        .step_count   (step_count),
        .start_period (start_period),
        .min_period   (min_period),
        .ramp_delta   (ramp_delta),
        .make_step    (make_step),
        .busy         (busy),
        .done         (done),
        .cur_period   (cur_period)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        else
            n_pass++;
    endtask

    // Start a move and log strobe cycles (relative to the start edge) until done.
    task automatic run_move(input int cnt, input int sp, input int mp, input int dl,
                            input int stop_at, input int restart_at, input int max_cyc);
        st_q.delete();
        done_t = -1;
        @(negedge clk);
        step_count   = 16'(cnt);
        start_period = 24'(sp);
        min_period   = 24'(mp);
        ramp_delta   = 24'(dl);
        start        = 1'b1;
        @(posedge clk);
        #1;
        start     = 1'b0;
        busy_seen = busy;
        for (int k = 1; k <= max_cyc; k++) begin
            stop  = (k == stop_at);
            start = (k == restart_at);
            if (k == restart_at) begin
                step_count   = 16'd2;
                start_period = 24'd3;
            end
            @(posedge clk);
            #1;
            stop  = 1'b0;
            start = 1'b0;
            if (make_step) st_q.push_back(k);
            busy_seen = busy_seen | busy;
            if (done) begin
                done_t = k;
                break;
            end
        end
    endtask

    task automatic cmp_run(input string tag, input int exp_s[$], input int exp_done);
        chk({tag, "_nstep"}, st_q.size(), exp_s.size());
        foreach (exp_s[i])
            chk($sformatf("%s_s%0d", tag, i), (i < st_q.size()) ? st_q[i] : -1, exp_s[i]);
        chk({tag, "_done_t"}, done_t, exp_done);
    endtask

    initial begin
        #2;
        chk("rst_make_step", 32'(make_step), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_cur_period", 32'(cur_period), 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        run_move(6, 10, 4, 2, 0, 0, 200);
        cmp_run("ramp", e_ramp, 43);
        chk("ramp_busy_seen", 32'(busy_seen), 1);
        chk("ramp_busy_end", 32'(busy), 0);
        chk("ramp_final_period", 32'(cur_period), 8);
        @(posedge clk);
        #1;
        chk("ramp_done_pulse", 32'(done), 0);

        run_move(5, 10, 4, 2, 0, 0, 200);
        cmp_run("short", e_short, 43);

        run_move(0, 10, 4, 2, 0, 0, 20);
        cmp_run("zero", e_none, 1);
        chk("zero_busy_seen", 32'(busy_seen), 0);

        // stop raised in the cycle strobe 5 is issued, while cruising with acc=3
        run_move(100, 10, 4, 2, 32, 0, 400);
        cmp_run("stop", e_stop, 57);

        // a second start mid-move (with other parameters) must be ignored
        run_move(6, 10, 4, 2, 0, 15, 200);
        cmp_run("restart", e_ramp, 43);

        run_move(3, 10, 20, 2, 0, 0, 200);
        cmp_run("clamp_min", e_clamp, 31);

        run_move(4, 0, 0, 2, 0, 0, 50);
        cmp_run("period0", e_fast, 5);
        chk("period0_cur", 32'(cur_period), 1);

        // asynchronous reset mid-interval
        @(negedge clk);
        step_count   = 16'd6;
        start_period = 24'd10;
        min_period   = 24'd4;
        ramp_delta   = 24'd2;
        start        = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (14) @(posedge clk);
        #1;
        chk("arst_pre_busy", 32'(busy), 1);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 0);
        chk("arst_cur_period", 32'(cur_period), 0);
        chk("arst_make_step", 32'(make_step), 0);
        chk("arst_done", 32'(done), 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        ev = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (make_step || done || busy) ev++;
        end
        chk("arst_quiet", ev, 0);

        run_move(6, 10, 4, 2, 0, 0, 200);
        cmp_run("after_rst", e_ramp, 43);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
